// File: rtl/stream_fork_sel_reg.sv
// -----------------------------------------------------------------------------
// stream_fork_sel_reg
//
// Registered stream fork with a per-beat destination mask. An accepted input
// beat is held in a single entry register. It is offered only to the outputs
// named by sel_i at acceptance time. Each output handshakes on its own. The
// entry retires in the cycle its last pending output handshakes, and a new beat
// can load on that same edge, so throughput is one beat per cycle.
//
// Parameters:
//   N_OUP   number of output streams (>= 1)
//   DATA_W  payload width in bits (>= 1)
//
// Ports:
//   clk_i    clock, rising edge
//   rst_ni   asynchronous active-low reset
//   valid_i  input beat valid
//   ready_o  input beat accepted when valid_i & ready_o
//   data_i   input payload
//   sel_i    destination mask, sampled with the input handshake
//   valid_o  per-output valid
//   ready_i  per-output ready
//   data_o   payload of the held entry, shared by all outputs
//   busy_o   entry register holds an unretired beat
// -----------------------------------------------------------------------------
module stream_fork_sel_reg #(
    parameter int N_OUP  = 2,
    parameter int DATA_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  logic              valid_i,
    output logic              ready_o,
    input  logic [DATA_W-1:0] data_i,
    input  logic [N_OUP-1:0]  sel_i,
    output logic [N_OUP-1:0]  valid_o,
    input  logic [N_OUP-1:0]  ready_i,
    output logic [DATA_W-1:0] data_o,
    output logic              busy_o
);

    logic              full_reg;
    logic [N_OUP-1:0]  pend_reg;
    logic [DATA_W-1:0] data_reg;

    logic [N_OUP-1:0]  pend_next;
    logic [N_OUP-1:0]  done;
    logic              retire;
    logic              accept;

    genvar gi;
    generate
        for (gi = 0; gi < N_OUP; gi++) begin : g_out
            // An output is offered the beat only while it still owes a handshake,
            // so outputs that already took the beat are not re-presented.
            assign valid_o[gi]   = full_reg & pend_reg[gi];
            // Done in this cycle: either it already handshook (or was never
            // selected), or it handshakes right now.
            assign done[gi]      = ~pend_reg[gi] | ready_i[gi];
            assign pend_next[gi] = pend_reg[gi] & ~ready_i[gi];
        end
    endgenerate

    assign retire = full_reg & (&done);

    // Only ready_i reaches ready_o combinationally; valid_i is never involved.
    // Reset gating keeps the producer from seeing acceptance during reset.
    assign ready_o = rst_ni & (~full_reg | retire);
    assign accept  = valid_i & ready_o;

    assign data_o = data_reg;
    assign busy_o = full_reg;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            full_reg <= 1'b0;
            pend_reg <= '0;
            data_reg <= '0;
        end else if (accept) begin
            // Loading overwrites pend, which also discards whatever the old
            // beat still owed; that is safe because accept while full implies
            // the old beat retires on this same edge. An all-zero mask
            // consumes the beat without ever occupying the entry.
            data_reg <= data_i;
            pend_reg <= sel_i;
            full_reg <= |sel_i;
        end else if (retire) begin
            full_reg <= 1'b0;
            pend_reg <= '0;
        end else if (full_reg) begin
            pend_reg <= pend_next;
        end
    end

endmodule
